// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit owning HI/LO; MUL_LAT/DIV_LAT busy cycles per long op, mthi/mtlo single-cycle.
// No backpressure: issue is only accepted while idle; busy tells the hazard unit to stall.
module mdu_unit #(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       mdop,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int LMAX = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CW   = $clog2(LMAX + 1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MADDU = 4'd8;
    localparam logic [3:0] OP_MSUB  = 4'd9;
    localparam logic [3:0] OP_MSUBU = 4'd10;

    typedef enum logic {IDLE, RUN} state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   res_q, res_d;
    logic                 wr_q, wr_d;
    logic [WIDTH-1:0]     hi_d, lo_d;

    logic [2*WIDTH-1:0]   acc, sa, sb, ua, ub, sprod, uprod, op_res;
    logic [WIDTH-1:0]     mag_a, mag_b, dvsr, uq, ur, quo, rem;
    logic                 a_neg, b_neg, is_div, is_long, accept;

    assign busy = (state_q == RUN);
    assign acc  = {hi, lo};

    assign sa    = {{WIDTH{a[WIDTH-1]}}, a};
    assign sb    = {{WIDTH{b[WIDTH-1]}}, b};
    assign ua    = {{WIDTH{1'b0}}, a};
    assign ub    = {{WIDTH{1'b0}}, b};
    assign sprod = sa * sb;
    assign uprod = ua * ub;

    // Signed divide done on magnitudes; this also yields lo=a, hi=0 for MIN/-1.
    assign is_div = (mdop == OP_DIV) || (mdop == OP_DIVU);
    assign a_neg  = (mdop == OP_DIV) && a[WIDTH-1];
    assign b_neg  = (mdop == OP_DIV) && b[WIDTH-1];
    assign mag_a  = a_neg ? -a : a;
    assign mag_b  = b_neg ? -b : b;
    assign dvsr   = (b == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : mag_b;
    assign uq     = mag_a / dvsr;
    assign ur     = mag_a % dvsr;
    assign quo    = (a_neg ^ b_neg) ? -uq : uq;
    assign rem    = a_neg ? -ur : ur;

    always_comb begin
        op_res  = acc;
        is_long = 1'b1;
        case (mdop)
            OP_MULT:         op_res = sprod;
            OP_MULTU:        op_res = uprod;
            OP_DIV, OP_DIVU: op_res = {rem, quo};
            OP_MADD:         op_res = acc + sprod;
            OP_MADDU:        op_res = acc + uprod;
            OP_MSUB:         op_res = acc - sprod;
            OP_MSUBU:        op_res = acc - uprod;
            default:         is_long = 1'b0;
        endcase
    end

    assign accept = start && (state_q == IDLE) && !cancel;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        wr_d    = wr_q;
        hi_d    = hi;
        lo_d    = lo;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (mdop == OP_MTHI) begin
                        hi_d = a;
                    end else if (mdop == OP_MTLO) begin
                        lo_d = a;
                    end else if (is_long) begin
                        state_d = RUN;
                        cnt_d   = is_div ? CW'(DIV_LAT) : CW'(MUL_LAT);
                        res_d   = op_res;
                        wr_d    = !(is_div && (b == '0));
                    end
                end
            end
            RUN: begin
                if (cancel) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    wr_d    = 1'b0;
                end else if (cnt_q == CW'(1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    wr_d    = 1'b0;
                    if (wr_q) begin
                        hi_d = res_q[2*WIDTH-1:WIDTH];
                        lo_d = res_q[WIDTH-1:0];
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            res_q   <= '0;
            wr_q    <= 1'b0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            wr_q    <= wr_d;
            hi      <= hi_d;
            lo      <= lo_d;
        end
    end

endmodule

// File: tb/tb_mdu_unit.sv
// Directed bench for mdu_unit: HI/LO results, busy duration, cancel, reset and ignored issues.
module tb_mdu_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  mdop;
    logic [31:0] a, b;
    logic        cancel;
    logic        busy;
    logic [31:0] hi, lo;

    int checks = 0;
    int errors = 0;
    int n;

    mdu_unit #(.WIDTH(32), .MUL_LAT(5), .DIV_LAT(10)) dut (
        .clk(clk), .reset(reset), .start(start), .mdop(mdop), .a(a), .b(b),
        .cancel(cancel), .busy(busy), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one issue cycle; returns in the cycle after the accept edge.
    task automatic issue(input logic [3:0] op, input logic [31:0] va, input logic [31:0] vb);
        start = 1'b1; mdop = op; a = va; b = vb;
        step();
        start = 1'b0; mdop = 4'd0;
    endtask

    // Count busy cycles until idle, bounded so a stuck busy still terminates.
    task automatic wait_idle(output int cnt);
        cnt = 0;
        while (busy === 1'b1 && cnt < 50) begin
            cnt++;
            step();
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        step();
        reset = 1'b1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %h want 0", busy); end
        checks++; if (hi !== 32'h0) begin errors++; $display("FAIL reset_hi got %h want 00000000", hi); end
        checks++; if (lo !== 32'h0) begin errors++; $display("FAIL reset_lo got %h want 00000000", lo); end
    endtask

    task automatic test_mult();
        issue(4'd1, 32'hFFFF_FFFE, 32'd3);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mult_busy_t1 got %h want 1", busy); end
        checks++; if ({hi, lo} !== 64'h0) begin errors++; $display("FAIL mult_hold got %h want 0", {hi, lo}); end
        wait_idle(n);
        checks++; if (n !== 5) begin errors++; $display("FAIL mult_busy_len got %0d want 5", n); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mult_busy_after got %h want 0", busy); end
        checks++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_hi got %h want ffffffff", hi); end
        checks++; if (lo !== 32'hFFFF_FFFA) begin errors++; $display("FAIL mult_lo got %h want fffffffa", lo); end
    endtask

    task automatic test_back_to_back();
        issue(4'd2, 32'hFFFF_FFFF, 32'd2);
        wait_idle(n);
        checks++; if ({hi, lo} !== 64'h0000_0001_FFFF_FFFE) begin errors++; $display("FAIL multu_res got %h want 00000001fffffffe", {hi, lo}); end
        issue(4'd4, 32'd7, 32'd2);
        wait_idle(n);
        checks++; if (n !== 10) begin errors++; $display("FAIL divu_busy_len got %0d want 10", n); end
        checks++; if (lo !== 32'd3) begin errors++; $display("FAIL divu_lo got %h want 00000003", lo); end
        checks++; if (hi !== 32'd1) begin errors++; $display("FAIL divu_hi got %h want 00000001", hi); end
    endtask

    task automatic test_div();
        issue(4'd3, 32'hFFFF_FFF9, 32'd2);
        wait_idle(n);
        checks++; if (lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_neg_lo got %h want fffffffd", lo); end
        checks++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_neg_hi got %h want ffffffff", hi); end
        issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle(n);
        checks++; if (lo !== 32'h8000_0000) begin errors++; $display("FAIL div_ovf_lo got %h want 80000000", lo); end
        checks++; if (hi !== 32'h0) begin errors++; $display("FAIL div_ovf_hi got %h want 00000000", hi); end
    endtask

    task automatic test_accumulate();
        issue(4'd5, 32'h1, 32'h0);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mthi_busy got %h want 0", busy); end
        checks++; if (hi !== 32'h1) begin errors++; $display("FAIL mthi_hi got %h want 00000001", hi); end
        issue(4'd6, 32'h0, 32'h0);
        checks++; if ({hi, lo} !== 64'h0000_0001_0000_0000) begin errors++; $display("FAIL mtlo_res got %h want 0000000100000000", {hi, lo}); end
        issue(4'd7, 32'd2, 32'd3);
        wait_idle(n);
        checks++; if ({hi, lo} !== 64'h0000_0001_0000_0006) begin errors++; $display("FAIL madd_res got %h want 0000000100000006", {hi, lo}); end
        issue(4'd10, 32'd0, 32'd5);
        wait_idle(n);
        checks++; if ({hi, lo} !== 64'h0000_0001_0000_0006) begin errors++; $display("FAIL msubu_res got %h want 0000000100000006", {hi, lo}); end
        issue(4'd9, 32'd1, 32'd7);
        wait_idle(n);
        checks++; if ({hi, lo} !== 64'h0000_0000_FFFF_FFFF) begin errors++; $display("FAIL msub_res got %h want 00000000ffffffff", {hi, lo}); end
    endtask

    task automatic test_divzero();
        issue(4'd5, 32'h12, 32'h0);
        issue(4'd6, 32'h34, 32'h0);
        issue(4'd4, 32'd5, 32'd0);
        wait_idle(n);
        checks++; if (n !== 10) begin errors++; $display("FAIL divz_busy_len got %0d want 10", n); end
        checks++; if ({hi, lo} !== 64'h0000_0012_0000_0034) begin errors++; $display("FAIL divz_res got %h want 0000001200000034", {hi, lo}); end
    endtask

    task automatic test_cancel();
        issue(4'd1, 32'd3, 32'd4);
        step();
        cancel = 1'b1;
        step();
        cancel = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cancel_busy got %h want 0", busy); end
        wait_idle(n);
        checks++; if ({hi, lo} !== 64'h0000_0012_0000_0034) begin errors++; $display("FAIL cancel_res got %h want 0000001200000034", {hi, lo}); end
        cancel = 1'b1;
        issue(4'd5, 32'h99, 32'h0);
        cancel = 1'b0;
        checks++; if (hi !== 32'h12) begin errors++; $display("FAIL cancel_idle_hi got %h want 00000012", hi); end
        issue(4'd3, 32'd100, 32'd7);
        step();
        step();
        reset = 1'b0;
        step();
        reset = 1'b1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got %h want 0", busy); end
        checks++; if ({hi, lo} !== 64'h0) begin errors++; $display("FAIL rst_mid_res got %h want 0", {hi, lo}); end
        step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_stay got %h want 0", busy); end
    endtask

    task automatic test_busy_start();
        issue(4'd1, 32'd5, 32'd6);
        start = 1'b1; mdop = 4'd2; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
        step();
        start = 1'b0; mdop = 4'd0;
        step();
        step();
        step();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL busy_last got %h want 1", busy); end
        start = 1'b1; mdop = 4'd5; a = 32'hDEAD;
        step();
        start = 1'b0; mdop = 4'd0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL commit_busy got %h want 0", busy); end
        checks++; if ({hi, lo} !== 64'h0000_0000_0000_001E) begin errors++; $display("FAIL busy_start_res got %h want 000000000000001e", {hi, lo}); end
        issue(4'd11, 32'h55, 32'h55);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reserved_busy got %h want 0", busy); end
        checks++; if ({hi, lo} !== 64'h0000_0000_0000_001E) begin errors++; $display("FAIL reserved_res got %h want 000000000000001e", {hi, lo}); end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; mdop = 4'd0; a = '0; b = '0; cancel = 1'b0;
        test_reset();
        test_mult();
        test_back_to_back();
        test_div();
        test_accumulate();
        test_divzero();
        test_cancel();
        test_busy_start();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
